// File: rtl/l2_snoop_responder.sv
// L2 line-fill snoop responder: fixed-latency reads from a 128-bit line store,
// with eviction write-back, fill forwarding and hotlink back-pressure.
module l2_snoop_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned IDX_W   = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  snooper_addr,
    input  logic         snooper_read_valid,
    input  logic         eviction_wren,
    input  logic [127:0] evictable_cacheline,
    input  logic         hotlink_interrupt,
    output logic [127:0] updated_cacheline,
    output logic         cacheline_update_valid,
    output logic         busy,
    output logic         req_overflow,
    output logic [15:0]  rd_count,
    output logic [15:0]  wr_count
);

    localparam int unsigned LINE_W = 128;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   req_idx_c;
    logic [IDX_W-1:0]   fill_idx_c;
    logic               accept_rd_c;
    logic               enter_resp_c;
    logic               unused_addr_bits_c;
    logic [LINE_W-1:0]  mem [DEPTH];

    assign req_idx_c          = snooper_addr[4 +: IDX_W];
    assign unused_addr_bits_c = ^{snooper_addr[31:4+IDX_W], snooper_addr[3:0]};

    // Next-state and countdown
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        accept_rd_c = 1'b0;
        case (state)
            IDLE: begin
                if (snooper_read_valid) begin
                    accept_rd_c = 1'b1;
                    cnt_nxt     = CNT_W'(LATENCY - 1);
                    state_nxt   = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) state_nxt = RESP;
                else                  cnt_nxt   = cnt - CNT_W'(1);
            end
            RESP: begin
                if (!hotlink_interrupt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp_c = (state_nxt == RESP) && (state != RESP);
    // On a direct IDLE->RESP entry the index has not been latched yet
    assign fill_idx_c   = (state == IDLE) ? req_idx_c : idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            cnt                    <= '0;
            idx_q                  <= '0;
            updated_cacheline      <= '0;
            cacheline_update_valid <= 1'b0;
            busy                   <= 1'b0;
            req_overflow           <= 1'b0;
            rd_count               <= '0;
            wr_count               <= '0;
        end else begin
            state                  <= state_nxt;
            cnt                    <= cnt_nxt;
            cacheline_update_valid <= (state_nxt == RESP);
            busy                   <= (state_nxt != IDLE);
            if (accept_rd_c) begin
                idx_q    <= req_idx_c;
                rd_count <= rd_count + 16'd1;
            end
            if (snooper_read_valid && (state != IDLE)) req_overflow <= 1'b1;
            if (eviction_wren) wr_count <= wr_count + 16'd1;
            // Same-edge eviction to the fill line bypasses the store read
            if (enter_resp_c) begin
                if (eviction_wren && (req_idx_c == fill_idx_c))
                    updated_cacheline <= evictable_cacheline;
                else
                    updated_cacheline <= mem[fill_idx_c];
            end
        end
    end

    // Backing store is deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        if (eviction_wren) mem[req_idx_c] <= evictable_cacheline;
    end

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Scoreboard bench for l2_snoop_responder: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_l2_snoop_responder;

    typedef struct {
        int           neg;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr,  addr1;
    logic         rv,    rv1;
    logic         ew,    ew1;
    logic [127:0] ev,    ev1;
    logic         hl,    hl1;
    logic [127:0] upd,   upd1;
    logic         vld,   vld1;
    logic         busy,  busy1;
    logic         ovf,   ovf1;
    logic [15:0]  rdc,   rdc1;
    logic [15:0]  wrc,   wrc1;

    exp_t q[$];
    exp_t q1[$];
    int   neg_cnt = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   exp_rd  = 0;
    int   exp_wr  = 0;

    l2_snoop_responder #(.LATENCY(4), .IDX_W(10)) dut (
        .clk(clk), .reset(reset), .snooper_addr(addr), .snooper_read_valid(rv),
        .eviction_wren(ew), .evictable_cacheline(ev), .hotlink_interrupt(hl),
        .updated_cacheline(upd), .cacheline_update_valid(vld), .busy(busy),
        .req_overflow(ovf), .rd_count(rdc), .wr_count(wrc)
    );

    l2_snoop_responder #(.LATENCY(1), .IDX_W(10)) dut1 (
        .clk(clk), .reset(reset), .snooper_addr(addr1), .snooper_read_valid(rv1),
        .eviction_wren(ew1), .evictable_cacheline(ev1), .hotlink_interrupt(hl1),
        .updated_cacheline(upd1), .cacheline_update_valid(vld1), .busy(busy1),
        .req_overflow(ovf1), .rd_count(rdc1), .wr_count(wrc1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every valid cycle must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        neg_cnt = neg_cnt + 1;
        if (vld) begin
            if (q.size() == 0) chk("l4_unexpected_valid", 128'(neg_cnt), 128'(0));
            else begin
                e = q.pop_front();
                chk("l4_valid_cycle", 128'(neg_cnt), 128'(e.neg));
                chk("l4_fill_data", upd, e.data);
            end
        end else if (q.size() > 0 && q[0].neg <= neg_cnt) begin
            e = q.pop_front();
            chk("l4_missed_valid", 128'(0), 128'(e.neg));
        end
        if (vld1) begin
            if (q1.size() == 0) chk("l1_unexpected_valid", 128'(neg_cnt), 128'(0));
            else begin
                e = q1.pop_front();
                chk("l1_valid_cycle", 128'(neg_cnt), 128'(e.neg));
                chk("l1_fill_data", upd1, e.data);
            end
        end else if (q1.size() > 0 && q1[0].neg <= neg_cnt) begin
            e = q1.pop_front();
            chk("l1_missed_valid", 128'(0), 128'(e.neg));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Index of the upcoming sampling edge, in monitor negedge units
    function automatic int edge_idx();
        return neg_cnt + 1;
    endfunction

    task automatic expect_fill(input int first, input int n, input logic [127:0] d);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.neg  = first + i;
            e.data = d;
            q.push_back(e);
        end
    endtask

    task automatic expect_fill1(input int first, input logic [127:0] d);
        exp_t e;
        e.neg  = first;
        e.data = d;
        q1.push_back(e);
    endtask

    task automatic evict(input logic [31:0] a, input logic [127:0] d);
        addr = a; ev = d; ew = 1'b1;
        exp_wr++;
        cyc();
        ew = 1'b0;
    endtask

    // Read with no interference: one valid cycle LATENCY edges later
    task automatic read4(input logic [31:0] a, input logic [127:0] d);
        addr = a; rv = 1'b1;
        expect_fill(edge_idx() + 4, 1, d);
        exp_rd++;
        cyc();
        rv = 1'b0;
    endtask

    initial begin
        int e;
        logic [127:0] aa, p200, p55, p77, pcc, pdd;
        aa   = {16{8'hAA}};
        p200 = {8{16'h1234}};
        p55  = {16{8'h55}};
        p77  = {16{8'h77}};
        pcc  = {16{8'hCC}};
        pdd  = {16{8'hDD}};

        reset = 1'b0;
        addr = '0; rv = 0; ew = 0; ev = '0; hl = 0;
        addr1 = '0; rv1 = 0; ew1 = 0; ev1 = '0; hl1 = 0;
        idle(3);
        chk("rst_valid", 128'(vld), 128'(0));
        chk("rst_data", upd, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ovf", 128'(ovf), 128'(0));
        chk("rst_rd", 128'(rdc), 128'(0));
        chk("rst_wr", 128'(wrc), 128'(0));
        reset = 1'b1;
        cyc();

        // Evict then read the same line
        evict(32'h0000_0100, aa);
        read4(32'h0000_0100, aa);
        chk("busy_wait", 128'(busy), 128'(1));
        idle(6);
        chk("basic_rd", 128'(rdc), 128'(exp_rd));
        chk("basic_wr", 128'(wrc), 128'(exp_wr));
        chk("basic_busy_idle", 128'(busy), 128'(0));

        // Hotlink holds RESP for three extra cycles
        evict(32'h0000_0200, p200);
        addr = 32'h0000_0200; rv = 1'b1;
        expect_fill(edge_idx() + 4, 4, p200);
        exp_rd++;
        cyc();
        rv = 1'b0;
        idle(3);
        hl = 1'b1;
        idle(3);
        hl = 1'b0;
        idle(6);

        // Eviction during WAIT to the pending line is returned
        evict(32'h0000_0300, {16{8'h0F}});
        addr = 32'h0000_0300; rv = 1'b1;
        expect_fill(edge_idx() + 4, 1, p55);
        exp_rd++;
        cyc();
        rv = 1'b0;
        ev = p55; ew = 1'b1; exp_wr++;
        cyc();
        ew = 1'b0;
        idle(6);
        // Address bit 14 is above the index, so this aliases line 0x300
        read4(32'h0000_4300, p55);
        idle(6);

        // Second read while busy is dropped and flagged
        read4(32'h0000_0100, aa);
        cyc();
        addr = 32'h0000_0200; rv = 1'b1;
        cyc();
        rv = 1'b0;
        idle(6);
        chk("ovf_flag", 128'(ovf), 128'(1));
        chk("ovf_rd", 128'(rdc), 128'(exp_rd));

        // Eviction on the RESP-entry edge is forwarded
        evict(32'h0000_0500, {16{8'h11}});
        read4(32'h0000_0500, pcc);
        idle(2);
        addr = 32'h0000_0500; ev = pcc; ew = 1'b1; exp_wr++;
        cyc();
        ew = 1'b0;
        idle(6);

        // Eviction during RESP leaves the loaded line alone
        addr = 32'h0000_0100; rv = 1'b1;
        expect_fill(edge_idx() + 4, 3, aa);
        exp_rd++;
        cyc();
        rv = 1'b0;
        idle(3);
        hl = 1'b1; ev = p77; ew = 1'b1; exp_wr++;
        cyc();
        ew = 1'b0;
        cyc();
        hl = 1'b0;
        idle(6);
        read4(32'h0000_0100, p77);
        idle(6);

        // Read and eviction of the same line together in IDLE
        addr = 32'h0000_0600; rv = 1'b1; ev = pdd; ew = 1'b1;
        expect_fill(edge_idx() + 4, 1, pdd);
        exp_rd++; exp_wr++;
        cyc();
        rv = 1'b0; ew = 1'b0;
        idle(6);
        chk("pre_rst_wr", 128'(wrc), 128'(exp_wr));

        // Reset mid-WAIT aborts the fill; store survives
        addr = 32'h0000_0100; rv = 1'b1;
        cyc();
        rv = 1'b0;
        cyc();
        reset = 1'b0;
        exp_rd = 0; exp_wr = 0;
        idle(2);
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(vld), 128'(0));
        chk("abort_rd", 128'(rdc), 128'(0));
        chk("abort_wr", 128'(wrc), 128'(0));
        chk("abort_ovf", 128'(ovf), 128'(0));
        reset = 1'b1;
        idle(8);
        read4(32'h0000_0100, p77);
        idle(6);
        chk("post_rst_rd", 128'(rdc), 128'(1));

        // LATENCY=1 instance
        addr1 = 32'h0000_0040; ev1 = {16{8'h99}}; ew1 = 1'b1;
        cyc();
        ew1 = 1'b0;
        addr1 = 32'h0000_0040; rv1 = 1'b1;
        expect_fill1(edge_idx() + 1, {16{8'h99}});
        cyc();
        rv1 = 1'b0;
        idle(2);
        addr1 = 32'h0000_0080; rv1 = 1'b1; ev1 = {16{8'hEE}}; ew1 = 1'b1;
        expect_fill1(edge_idx() + 1, {16{8'hEE}});
        cyc();
        rv1 = 1'b0; ew1 = 1'b0;
        idle(2);
        chk("l1_rd", 128'(rdc1), 128'(2));
        addr1 = 32'h0000_0000; ew1 = 1'b1;
        for (int i = 0; i < 65533; i++) begin
            ev1 = 128'(i);
            cyc();
        end
        ew1 = 1'b0;
        chk("l1_wr_max", 128'(wrc1), 128'(16'hFFFF));
        ew1 = 1'b1;
        cyc();
        ew1 = 1'b0;
        chk("l1_wr_wrap", 128'(wrc1), 128'(0));

        for (int i = 0; i < 20 && (q.size() != 0 || q1.size() != 0); i++) cyc();
        chk("l4_queue_drained", 128'(q.size()), 128'(0));
        chk("l1_queue_drained", 128'(q1.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
